// File: rtl/hpdcache_fence_ctrl_if.sv
// rtl/hpdcache_fence_ctrl_if.sv - fence controller handshake bundle (fence, store, flush, status)
interface hpdcache_fence_ctrl_if;
   logic       fence_req_i;
   logic       fence_i_i;
   logic       fence_ack_o;
   logic       store_issue_i;
   logic       store_done_i;
   logic       store_stall_o;
   logic       flush_req_o;
   logic       flush_inval_o;
   logic       flush_ack_i;
   logic       icache_flush_o;
   logic       busy_o;
   logic [3:0] outstanding_o;
   logic       err_o;

   modport slave (
      input  fence_req_i,
      input  fence_i_i,
      input  store_issue_i,
      input  store_done_i,
      input  flush_ack_i,
      output fence_ack_o,
      output store_stall_o,
      output flush_req_o,
      output flush_inval_o,
      output icache_flush_o,
      output busy_o,
      output outstanding_o,
      output err_o
   );

   modport master (
      output fence_req_i,
      output fence_i_i,
      output store_issue_i,
      output store_done_i,
      output flush_ack_i,
      input  fence_ack_o,
      input  store_stall_o,
      input  flush_req_o,
      input  flush_inval_o,
      input  icache_flush_o,
      input  busy_o,
      input  outstanding_o,
      input  err_o
   );
endinterface

// File: rtl/hpdcache_fence_ctrl.sv
// rtl/hpdcache_fence_ctrl.sv - fence/fence.i sequencer: drain stores, flush dcache, flush icache, ack
module hpdcache_fence_ctrl #(
   parameter int unsigned MAX_OUTSTANDING     = 7,
   parameter bit          FLUSH_ON_FENCE      = 1'b1,
   parameter bit          INVALIDATE_ON_FLUSH = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   hpdcache_fence_ctrl_if.slave fc_if
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAIN  = 3'd1,
      FLUSH  = 3'd2,
      ICACHE = 3'd3,
      DONE   = 3'd4
   } state_e;

   localparam logic [3:0] CNT_MAX = 4'(MAX_OUTSTANDING);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       is_fi_q, is_fi_d;
   logic       err_q, err_d;

   logic busy;
   logic issue_only;
   logic done_only;

   assign busy       = (state_q != IDLE);
   assign issue_only = fc_if.store_issue_i & ~fc_if.store_done_i;
   assign done_only  = fc_if.store_done_i & ~fc_if.store_issue_i;

   // Counter saturates at both ends; an out-of-range step is a protocol error.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (issue_only) begin
         if (cnt_q == CNT_MAX) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end else if (done_only) begin
         if (cnt_q == 4'd0) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end
      if (fc_if.store_issue_i && busy) begin
         err_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      is_fi_d = is_fi_q;
      unique case (state_q)
         IDLE: begin
            if (fc_if.fence_req_i) begin
               is_fi_d = fc_if.fence_i_i;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // A store accepted this cycle is still in flight, so the drain is not complete yet.
            if ((cnt_q == 4'd0) && !fc_if.store_issue_i) begin
               if (FLUSH_ON_FENCE) begin
                  state_d = FLUSH;
               end else if (is_fi_q) begin
                  state_d = ICACHE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FLUSH: begin
            if (fc_if.flush_ack_i) begin
               state_d = is_fi_q ? ICACHE : DONE;
            end
         end
         ICACHE:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         is_fi_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_fi_q <= is_fi_d;
         err_q   <= err_d;
      end
   end

   // All handshake outputs decode the registered state, so reset clears them immediately.
   assign fc_if.busy_o         = busy;
   assign fc_if.store_stall_o  = busy | (cnt_q == CNT_MAX);
   assign fc_if.flush_req_o    = (state_q == FLUSH);
   assign fc_if.flush_inval_o  = (state_q == FLUSH) & INVALIDATE_ON_FLUSH;
   assign fc_if.icache_flush_o = (state_q == ICACHE);
   assign fc_if.fence_ack_o    = (state_q == DONE);
   assign fc_if.outstanding_o  = cnt_q;
   assign fc_if.err_o          = err_q;

endmodule

// File: tb/tb_hpdcache_fence_ctrl.sv
// tb/tb_hpdcache_fence_ctrl.sv - three parameterisations on shared stimulus, checked against a step-list model
module tb_hpdcache_fence_ctrl;

   localparam int NDUT = 3;

   function automatic int maxo_of(input int g);
      return (g == 2) ? 3 : 7;
   endfunction
   function automatic bit fof_of(input int g);
      return (g != 1);
   endfunction
   function automatic bit inv_of(input int g);
      return (g != 0);
   endfunction

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic fence_req = 1'b0, fence_i = 1'b0, issue = 1'b0, done = 1'b0, flush_ack = 1'b0;

   logic       o_ack [NDUT];
   logic       o_stall [NDUT];
   logic       o_freq [NDUT];
   logic       o_finv [NDUT];
   logic       o_icf [NDUT];
   logic       o_busy [NDUT];
   logic       o_err [NDUT];
   logic [3:0] o_out [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      hpdcache_fence_ctrl_if bus ();
      assign bus.fence_req_i   = fence_req;
      assign bus.fence_i_i     = fence_i;
      assign bus.store_issue_i = issue;
      assign bus.store_done_i  = done;
      assign bus.flush_ack_i   = flush_ack;
      assign o_ack[g]   = bus.fence_ack_o;
      assign o_stall[g] = bus.store_stall_o;
      assign o_freq[g]  = bus.flush_req_o;
      assign o_finv[g]  = bus.flush_inval_o;
      assign o_icf[g]   = bus.icache_flush_o;
      assign o_busy[g]  = bus.busy_o;
      assign o_err[g]   = bus.err_o;
      assign o_out[g]   = bus.outstanding_o;
      hpdcache_fence_ctrl #(
         .MAX_OUTSTANDING    (maxo_of(g)),
         .FLUSH_ON_FENCE     (fof_of(g)),
         .INVALIDATE_ON_FLUSH(inv_of(g))
      ) u_dut (
         .clk_i (clk),
         .rst_ni(rst_n),
         .fc_if (bus)
      );
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: an accepted fence becomes a list of steps (D=drain, F=flush, I=icache, A=ack); '-' is idle.
   int  m_cnt [NDUT] = '{0, 0, 0};
   bit  m_err [NDUT] = '{0, 0, 0};
   int  m_n   [NDUT] = '{0, 0, 0};
   int  m_pos [NDUT] = '{0, 0, 0};
   byte m_steps [NDUT][4];

   function automatic byte cur(input int i);
      return (m_pos[i] < m_n[i]) ? m_steps[i][m_pos[i]] : "-";
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NDUT; i++) begin
            m_cnt[i] <= 0;
            m_err[i] <= 1'b0;
            m_n[i]   <= 0;
            m_pos[i] <= 0;
         end
      end else begin
         for (int i = 0; i < NDUT; i++) begin
            byte s;
            int  c;
            int  k;
            byte lst [4];
            s = cur(i);
            c = m_cnt[i];
            if ((issue && s != "-") ||
                (issue && !done && c == maxo_of(i)) ||
                (done && !issue && c == 0))
               m_err[i] <= 1'b1;
            if (issue && !done && c < maxo_of(i)) m_cnt[i] <= c + 1;
            if (done && !issue && c > 0)          m_cnt[i] <= c - 1;
            case (s)
               "-": if (fence_req) begin
                  k = 0;
                  lst = '{"A", "A", "A", "A"};
                  lst[k] = "D"; k++;
                  if (fof_of(i)) begin lst[k] = "F"; k++; end
                  if (fence_i)   begin lst[k] = "I"; k++; end
                  lst[k] = "A"; k++;
                  m_steps[i] <= lst;
                  m_n[i]     <= k;
                  m_pos[i]   <= 0;
               end
               "D": if (c == 0 && !issue) m_pos[i] <= m_pos[i] + 1;
               "F": if (flush_ack) m_pos[i] <= m_pos[i] + 1;
               default: m_pos[i] <= m_pos[i] + 1;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         byte s;
         bit  bsy;
         s   = cur(i);
         bsy = (s != "-");
         chk($sformatf("u%0d.busy", i),  int'(o_busy[i]),  int'(bsy));
         chk($sformatf("u%0d.stall", i), int'(o_stall[i]), int'(bsy || m_cnt[i] == maxo_of(i)));
         chk($sformatf("u%0d.freq", i),  int'(o_freq[i]),  int'(s == "F"));
         chk($sformatf("u%0d.finv", i),  int'(o_finv[i]),  int'(s == "F" && inv_of(i)));
         chk($sformatf("u%0d.icf", i),   int'(o_icf[i]),   int'(s == "I"));
         chk($sformatf("u%0d.ack", i),   int'(o_ack[i]),   int'(s == "A"));
         chk($sformatf("u%0d.out", i),   int'(o_out[i]),   m_cnt[i]);
         chk($sformatf("u%0d.err", i),   int'(o_err[i]),   int'(m_err[i]));
      end
   end

   int ack_cnt0 = 0;
   int icf_cnt0 = 0;
   always @(negedge clk) begin
      if (o_ack[0]) ack_cnt0 <= ack_cnt0 + 1;
      if (o_icf[0]) icf_cnt0 <= icf_cnt0 + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      fence_req = 1'b0; fence_i = 1'b0; issue = 1'b0; done = 1'b0; flush_ack = 1'b0;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      int a0;
      int ic0;
      int nf;

      #2;
      chk("rst.busy",  int'(o_busy[0]),  0);
      chk("rst.stall", int'(o_stall[0]), 0);
      chk("rst.freq",  int'(o_freq[0]),  0);
      chk("rst.finv",  int'(o_finv[1]),  0);
      chk("rst.ack",   int'(o_ack[0]),   0);
      chk("rst.out",   int'(o_out[0]),   0);
      chk("rst.err",   int'(o_err[0]),   0);
      @(posedge clk); #2;
      rst_n = 1'b1;

      // saturation at MAX_OUTSTANDING
      do_reset();
      issue = 1'b1;
      repeat (7) cyc();
      chk("sat.out7",   int'(o_out[0]),   7);
      chk("sat.stall",  int'(o_stall[0]), 1);
      chk("sat.err0",   int'(o_err[0]),   0);
      cyc();
      issue = 1'b0;
      chk("sat.out8",   int'(o_out[0]),   7);
      chk("sat.err1",   int'(o_err[0]),   1);

      // simultaneous issue+done, then underflow
      do_reset();
      issue = 1'b1;
      repeat (4) cyc();
      done = 1'b1;
      cyc();
      chk("both.out4", int'(o_out[0]), 4);
      issue = 1'b0;
      repeat (4) cyc();
      chk("under.out0", int'(o_out[0]), 0);
      chk("under.err0", int'(o_err[0]), 0);
      cyc();
      done = 1'b0;
      chk("under.out", int'(o_out[0]), 0);
      chk("under.err", int'(o_err[0]), 1);

      // fence waits for the drain before flushing
      do_reset();
      ic0 = icf_cnt0;
      issue = 1'b1;
      repeat (3) cyc();
      issue = 1'b0;
      fence_req = 1'b1;
      cyc();
      fence_req = 1'b0;
      chk("drain.busy",  int'(o_busy[0]),  1);
      chk("drain.stall", int'(o_stall[0]), 1);
      for (int k = 0; k < 5; k++) begin
         done = (k % 2 == 0);
         cyc();
         chk($sformatf("drain.freq%0d", k), int'(o_freq[0]), 0);
      end
      done = 1'b0;
      cyc();
      chk("drain.freq_up", int'(o_freq[0]), 1);
      chk("drain.out",     int'(o_out[0]),  0);
      flush_ack = 1'b1;
      cyc();
      flush_ack = 1'b0;
      chk("drain.ack",  int'(o_ack[0]),  1);
      chk("drain.freq", int'(o_freq[0]), 0);
      cyc();
      chk("drain.ack_end", int'(o_ack[0]), 0);
      chk("drain.idle",    int'(o_busy[0]), 0);
      chk("drain.no_icf",  icf_cnt0 - ic0,  0);

      // fence.i with a four-cycle flush
      do_reset();
      fence_req = 1'b1; fence_i = 1'b1;
      cyc();
      fence_req = 1'b0; fence_i = 1'b0;
      cyc();
      nf = 0;
      for (int k = 0; k < 4; k++) begin
         if (o_freq[0]) nf++;
         flush_ack = (k == 3);
         cyc();
      end
      flush_ack = 1'b0;
      chk("fi.flush_cycles", nf, 4);
      chk("fi.icf",  int'(o_icf[0]),  1);
      chk("fi.freq", int'(o_freq[0]), 0);
      cyc();
      chk("fi.icf_end", int'(o_icf[0]), 0);
      chk("fi.ack",     int'(o_ack[0]), 1);
      cyc();
      chk("fi.ack_end", int'(o_ack[0]), 0);

      // minimum latency: T+2 without flush, T+3 with flush held acked
      do_reset();
      flush_ack = 1'b1;
      fence_req = 1'b1;
      cyc();
      fence_req = 1'b0;
      chk("lat.u1_t1_ack", int'(o_ack[1]), 0);
      cyc();
      chk("lat.u1_t2_ack",  int'(o_ack[1]),  1);
      chk("lat.u1_freq",    int'(o_freq[1]), 0);
      chk("lat.u0_freq",    int'(o_freq[0]), 1);
      chk("lat.u0_finv",    int'(o_finv[0]), 0);
      chk("lat.u2_finv",    int'(o_finv[2]), 1);
      cyc();
      chk("lat.u0_t3_ack",  int'(o_ack[0]),  1);
      chk("lat.u2_t3_ack",  int'(o_ack[2]),  1);
      chk("lat.u1_idle",    int'(o_busy[1]), 0);
      flush_ack = 1'b0;
      cyc();

      // repeated fence_req during DRAIN yields one ack
      do_reset();
      a0 = ack_cnt0;
      issue = 1'b1;
      cyc();
      issue = 1'b0;
      fence_req = 1'b1;
      cyc();
      cyc();
      done = 1'b1;
      cyc();
      done = 1'b0;
      fence_req = 1'b0;
      cyc();
      chk("dbl.freq", int'(o_freq[0]), 1);
      flush_ack = 1'b1;
      cyc();
      flush_ack = 1'b0;
      repeat (6) cyc();
      chk("dbl.one_ack", ack_cnt0 - a0, 1);

      // reset during FLUSH aborts the fence asynchronously
      fence_req = 1'b1;
      cyc();
      fence_req = 1'b0;
      cyc();
      chk("rflush.freq_pre", int'(o_freq[0]), 1);
      a0 = ack_cnt0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rflush.freq", int'(o_freq[0]), 0);
      chk("rflush.finv", int'(o_finv[2]), 0);
      chk("rflush.busy", int'(o_busy[0]), 0);
      flush_ack = 1'b1;
      cyc();
      rst_n = 1'b1;
      flush_ack = 1'b0;
      repeat (4) cyc();
      chk("rflush.no_ack", ack_cnt0 - a0, 0);

      // randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         issue     = ($urandom_range(0, 1) == 0);
         done      = ($urandom_range(0, 2) == 0);
         fence_req = ($urandom_range(0, 7) == 0);
         fence_i   = ($urandom_range(0, 1) == 0);
         flush_ack = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
         end else begin
            cyc();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
